// File: rtl/sfifo_wb_bridge.sv
// sfifo_wb_bridge: Wishbone slave front-end for the servo sync-FIFO, base-period
// tick counter, DOUT set/reset pulse generator and DIN GPIO port.
// A 2-entry prefetch buffer hides FIFO read latency on DI reads; a bounded stall
// counter turns a starved DI read into a zero-data ack plus a sticky underrun flag.
// Optional feature: define SFIFO_WB_DIN_EDGE_EN to add the sticky DIN rising-edge
// register at word offset 5 (otherwise offset 5 reads 0 and no edge logic exists).
module sfifo_wb_bridge #(
    parameter int WB_AW      = 6,
    parameter int WB_DW      = 32,
    parameter int SFIFO_DW   = 16,
    parameter int DOUT_W     = 16,
    parameter int DIN_W      = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [WB_AW-3:0]    wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                sfifo_rd_o,
    input  logic                sfifo_empty_i,
    input  logic [SFIFO_DW-1:0] sfifo_di,
    input  logic                sfifo_bp_tick_i,
    output logic [DOUT_W-1:0]   dout_set_o,
    output logic [DOUT_W-1:0]   dout_rst_o,
    input  logic [DIN_W-1:0]    din_i
);

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [WB_AW-3:0] ADR_BP   = (WB_AW-2)'(0);
    localparam logic [WB_AW-3:0] ADR_CTRL = (WB_AW-2)'(1);
    localparam logic [WB_AW-3:0] ADR_DI   = (WB_AW-2)'(2);
    localparam logic [WB_AW-3:0] ADR_DOUT = (WB_AW-2)'(3);
    localparam logic [WB_AW-3:0] ADR_DIN  = (WB_AW-2)'(4);
    localparam logic [WB_AW-3:0] ADR_EDGE = (WB_AW-2)'(5);

    logic                req_s, di_rd_s, di_hit_s, di_stall_s, tmo_s, ack_d_s;
    logic                ctrl_wr_s, dout_cmd_s, bp_rise_s, empty_s;
    logic [DOUT_W-1:0]   dout_onehot_s;
    logic [WB_DW-1:0]    rdata_s;
    logic [1:0]          occ_nxt_s;
    logic                wr_idx_s;

    logic [SFIFO_DW-1:0] buf_r [2];
    logic                head_r, inflight_r, underrun_r;
    logic [1:0]          occ_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic                bp_s1_r, bp_s2_r, bp_prev_r;
    logic [WB_DW-1:0]    bp_cnt_r;
    logic [WB_DW-1:0]    wb_dat_r;
    logic                wb_ack_r;
    logic [DOUT_W-1:0]   dout_set_r, dout_rst_r;

    assign wb_dat_o   = wb_dat_r;
    assign wb_ack_o   = wb_ack_r;
    assign dout_set_o = dout_set_r;
    assign dout_rst_o = dout_rst_r;

    // A new request is any strobed cycle not already being acknowledged.
    assign req_s      = wb_cyc_i & wb_stb_i & ~wb_ack_r;
    assign di_rd_s    = req_s & ~wb_we_i & (wb_adr_i == ADR_DI);
    assign empty_s    = (occ_r == 2'd0);
    assign di_hit_s   = di_rd_s & ~empty_s;
    assign tmo_s      = di_rd_s & empty_s & (tmo_cnt_r == TMO_W'(RD_TIMEOUT - 1));
    assign di_stall_s = di_rd_s & empty_s & ~tmo_s;
    assign ack_d_s    = (req_s & ~di_rd_s) | di_hit_s | tmo_s;
    assign ctrl_wr_s  = req_s & wb_we_i & (wb_adr_i == ADR_CTRL);
    assign bp_rise_s  = bp_s2_r & ~bp_prev_r;

    // Keep at most two entries buffered, counting the word already requested.
    assign sfifo_rd_o = ~sfifo_empty_i & (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd2);
    assign wr_idx_s   = head_r ^ occ_r[0];

    // DOUT command decode: enabled, byte lane 0 selected, index in range.
    assign dout_cmd_s    = req_s & wb_we_i & (wb_adr_i == ADR_DOUT) & wb_sel_i[0] &
                           wb_dat_i[7] & (32'(wb_dat_i[5:0]) < DOUT_W);
    assign dout_onehot_s = DOUT_W'(1'b1) << wb_dat_i[5:0];

`ifdef SFIFO_WB_DIN_EDGE_EN
    logic [DIN_W-1:0] din_prev_r, din_edge_r, edge_clr_s;
    assign edge_clr_s = (req_s & wb_we_i & (wb_adr_i == ADR_EDGE)) ? wb_dat_i[DIN_W-1:0]
                                                                     : {DIN_W{1'b0}};

    // Sticky rising-edge capture; a new edge beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            din_prev_r <= {DIN_W{1'b0}};
            din_edge_r <= {DIN_W{1'b0}};
        end else begin
            din_prev_r <= din_i;
            din_edge_r <= (din_edge_r & ~edge_clr_s) | (din_i & ~din_prev_r);
        end
    end
`endif

    // Buffer occupancy after this cycle's push (landing word) and pop (DI hit).
    always_comb begin
        occ_nxt_s = occ_r;
        case ({inflight_r, di_hit_s})
            2'b10:   occ_nxt_s = occ_r + 2'd1;
            2'b01:   occ_nxt_s = occ_r - 2'd1;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Prefetch buffer: capture the FIFO word the cycle after the pop, pop at head.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            buf_r[0]   <= {SFIFO_DW{1'b0}};
            buf_r[1]   <= {SFIFO_DW{1'b0}};
            head_r     <= 1'b0;
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            if (inflight_r) begin
                buf_r[wr_idx_s] <= sfifo_di;
            end
            if (di_hit_s) begin
                head_r <= ~head_r;
            end
            occ_r      <= occ_nxt_s;
            inflight_r <= sfifo_rd_o;
        end
    end

    // Stall counter for starved DI reads; cleared by any ack or an aborted read.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_r <= TMO_W'(0);
        end else if (di_stall_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= TMO_W'(0);
        end
    end

    // Sticky underrun: a timeout in the same cycle as a write-1-clear wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            underrun_r <= 1'b0;
        end else if (tmo_s) begin
            underrun_r <= 1'b1;
        end else if (ctrl_wr_s & wb_dat_i[1]) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    // Base-period tick: synchronise, detect rising edge, count (wraps naturally).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bp_s1_r   <= 1'b0;
            bp_s2_r   <= 1'b0;
            bp_prev_r <= 1'b0;
            bp_cnt_r  <= {WB_DW{1'b0}};
        end else begin
            bp_s1_r   <= sfifo_bp_tick_i;
            bp_s2_r   <= bp_s1_r;
            bp_prev_r <= bp_s2_r;
            if (bp_rise_s) begin
                bp_cnt_r <= bp_cnt_r + WB_DW'(1);
            end
        end
    end

    // Read data mux; a starved DI read (timeout) returns zero.
    always_comb begin
        rdata_s = {WB_DW{1'b0}};
        if (!wb_we_i) begin
            case (wb_adr_i)
                ADR_BP:   rdata_s = bp_cnt_r;
                ADR_CTRL: rdata_s = WB_DW'({occ_r, underrun_r, empty_s});
                ADR_DI:   rdata_s = empty_s ? {WB_DW{1'b0}} : WB_DW'(buf_r[head_r]);
                ADR_DIN:  rdata_s = WB_DW'(din_i);
`ifdef SFIFO_WB_DIN_EDGE_EN
                ADR_EDGE: rdata_s = WB_DW'(din_edge_r);
`endif
                default:  rdata_s = {WB_DW{1'b0}};
            endcase
        end else begin
            rdata_s = {WB_DW{1'b0}};
        end
    end

    // Registered bus response: single-cycle ack with data, zero otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_r <= 1'b0;
            wb_dat_r <= {WB_DW{1'b0}};
        end else begin
            wb_ack_r <= ack_d_s;
            wb_dat_r <= ack_d_s ? rdata_s : {WB_DW{1'b0}};
        end
    end

    // DOUT pulses last exactly one cycle; set and reset are mutually exclusive.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dout_set_r <= {DOUT_W{1'b0}};
            dout_rst_r <= {DOUT_W{1'b0}};
        end else if (dout_cmd_s) begin
            dout_set_r <= wb_dat_i[6] ? dout_onehot_s : {DOUT_W{1'b0}};
            dout_rst_r <= wb_dat_i[6] ? {DOUT_W{1'b0}} : dout_onehot_s;
        end else begin
            dout_set_r <= {DOUT_W{1'b0}};
            dout_rst_r <= {DOUT_W{1'b0}};
        end
    end

endmodule
